// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the modulo counter family.
// Mode/direction encodings plus a width-sizing helper.
package cnt_pkg;

  localparam int SAT_WRAP = 0;
  localparam int SAT_HOLD = 1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_STEP
  } op_e;

  // Bits needed to hold 0..m-1, never less than one.
  function automatic int clog2_mod(input longint m);
    int w;
    w = 1;
    for (int i = 1; i < 63; i++) begin
      if ((64'sd1 <<< i) < m) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with load, clear,
// wrap/saturate modes and a combinational cascade carry.
module mod_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped,
  output logic             sat
);

  localparam longint SPAN = 64'sd1 <<< WIDTH;

  if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > SPAN) begin : g_bad
    $error("mod_counter: illegal WIDTH/MODULUS");
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  op_e              op;
  logic             at_lim;
  logic [WIDTH-1:0] count_d;
  logic             wrapped_d;
  logic             sat_d;

  always_comb begin
    op = OP_HOLD;
    if (clr)       op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_STEP;
  end

  assign at_lim = (up == DIR_UP) ? (count == LAST)
                                 : (count == '0);

  assign tc = en & ~clr & ~load & at_lim;

  always_comb begin
    count_d   = count;
    wrapped_d = 1'b0;
    sat_d     = sat;
    unique case (op)
      OP_CLR: begin
        count_d = '0;
        sat_d   = 1'b0;
      end
      OP_LOAD: begin
        count_d = (load_val > LAST) ? LAST : load_val;
        sat_d   = 1'b0;
      end
      OP_STEP: begin
        if (at_lim) begin
          if (SATURATE == SAT_HOLD) begin
            sat_d = 1'b1;
          end else begin
            count_d   = (up == DIR_UP) ? '0 : LAST;
            wrapped_d = 1'b1;
          end
        end else begin
          // Off the limit, so neither step can leave 0..LAST.
          count_d = (up == DIR_UP) ? count + WIDTH'(1)
                                   : count - WIDTH'(1);
          sat_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      wrapped <= 1'b0;
      sat     <= 1'b0;
    end else begin
      count   <= count_d;
      wrapped <= wrapped_d;
      sat     <= sat_d;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Randomised and directed checks of mod_counter against
// an arithmetic reference model, plus a two-digit cascade.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr, load, en, up, cen;
  logic [3:0] load_val;

  logic [3:0] cnt_w, cnt_s, cnt_p, cnt_lo, cnt_hi;
  logic tc_w, tc_s, tc_p, tc_lo, tc_hi;
  logic wr_w, wr_s, wr_p, wr_lo, wr_hi;
  logic sat_w, sat_s, sat_p, sat_lo, sat_hi;

  int n_checks = 0;
  int n_fail   = 0;

  const int MODS[3] = '{10, 10, 16};
  const int SATS[3] = '{0, 1, 0};
  int m_c[3];
  int m_w[3];
  int m_s[3];
  int m_cas;
  logic last_tc_w;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load),
    .load_val(load_val), .en(en), .up(up),
    .count(cnt_w), .tc(tc_w), .wrapped(wr_w), .sat(sat_w));

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load),
    .load_val(load_val), .en(en), .up(up),
    .count(cnt_s), .tc(tc_s), .wrapped(wr_s), .sat(sat_s));

  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_pow2 (
    .clk(clk), .rst(rst), .clr(clr), .load(load),
    .load_val(load_val), .en(en), .up(up),
    .count(cnt_p), .tc(tc_p), .wrapped(wr_p), .sat(sat_p));

  mod_counter u_lo (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .en(cen), .up(1'b1),
    .count(cnt_lo), .tc(tc_lo), .wrapped(wr_lo), .sat(sat_lo));

  mod_counter u_hi (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .en(tc_lo), .up(1'b1),
    .count(cnt_hi), .tc(tc_hi), .wrapped(wr_hi), .sat(sat_hi));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_c[i] = 0;
      m_w[i] = 0;
      m_s[i] = 0;
    end
    m_cas = 0;
  endtask

  function automatic int exp_tc(input int i);
    int lim;
    lim = up ? MODS[i] - 1 : 0;
    return (en && !clr && !load && m_c[i] == lim) ? 1 : 0;
  endfunction

  // Next state from the behavioural rules, one instance at a time.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int top;
      top = MODS[i] - 1;
      m_w[i] = 0;
      if (clr) begin
        m_c[i] = 0;
        m_s[i] = 0;
      end else if (load) begin
        m_c[i] = (int'(load_val) > top) ? top : int'(load_val);
        m_s[i] = 0;
      end else if (en) begin
        if (up && m_c[i] == top) begin
          if (SATS[i] != 0) m_s[i] = 1;
          else begin m_c[i] = 0; m_w[i] = 1; end
        end else if (!up && m_c[i] == 0) begin
          if (SATS[i] != 0) m_s[i] = 1;
          else begin m_c[i] = top; m_w[i] = 1; end
        end else begin
          m_c[i] = up ? m_c[i] + 1 : m_c[i] - 1;
          m_s[i] = 0;
        end
      end
    end
    if (cen) m_cas = (m_cas + 1) % 100;
  endtask

  task automatic check_all();
    check("cnt_w", int'(cnt_w), m_c[0]);
    check("wr_w", int'(wr_w), m_w[0]);
    check("sat_w", int'(sat_w), m_s[0]);
    check("cnt_s", int'(cnt_s), m_c[1]);
    check("wr_s", int'(wr_s), m_w[1]);
    check("sat_s", int'(sat_s), m_s[1]);
    check("cnt_p", int'(cnt_p), m_c[2]);
    check("wr_p", int'(wr_p), m_w[2]);
    check("cascade", int'(cnt_hi) * 10 + int'(cnt_lo), m_cas);
  endtask

  task automatic step(input logic c, input logic l,
                      input logic [3:0] lv, input logic e,
                      input logic u, input logic ce);
    @(negedge clk);
    clr = c; load = l; load_val = lv;
    en = e; up = u; cen = ce;
    #1;
    check("tc_w", int'(tc_w), exp_tc(0));
    check("tc_s", int'(tc_s), exp_tc(1));
    check("tc_p", int'(tc_p), exp_tc(2));
    check("tc_lo", int'(tc_lo), (ce && m_cas % 10 == 9) ? 1 : 0);
    last_tc_w = tc_w;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0;
    clr = 0; load = 0; load_val = 0;
    en = 0; up = 1; cen = 0;
    last_tc_w = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(0, 0, 4'd0, 1, 1, 0);
      check("up_seq", int'(cnt_w), (i + 1) % 10);
      check("up_tc", int'(last_tc_w), (i == 9) ? 1 : 0);
      check("up_wrap", int'(wr_w), (i == 9) ? 1 : 0);
    end

    step(1, 0, 4'd0, 0, 1, 0);
    step(0, 0, 4'd0, 1, 0, 0);
    check("dn_tc0", int'(last_tc_w), 1);
    check("dn_to9", int'(cnt_w), 9);
    check("dn_wrap", int'(wr_w), 1);
    step(0, 0, 4'd0, 1, 0, 0);
    check("dn_to8", int'(cnt_w), 8);
    check("dn_wrap1", int'(wr_w), 0);

    step(0, 1, 4'd7, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'd0, 1, 1, 0);
      check("sat_seq", int'(cnt_s), (i == 0) ? 8 : 9);
      check("sat_flag", int'(sat_s), (i >= 2) ? 1 : 0);
    end
    step(0, 0, 4'd0, 1, 0, 0);
    check("sat_rev", int'(cnt_s), 8);
    check("sat_rev_f", int'(sat_s), 0);

    step(0, 1, 4'd12, 0, 1, 0);
    check("ld_clamp", int'(cnt_w), 9);
    check("ld_p2", int'(cnt_p), 12);
    step(1, 1, 4'd5, 0, 1, 0);
    check("clr_ld", int'(cnt_w), 0);
    step(0, 1, 4'd5, 1, 1, 0);
    check("ld_en", int'(cnt_w), 5);

    step(1, 0, 4'd0, 0, 1, 0);
    repeat (6) step(0, 0, 4'd0, 1, 1, 0);
    check("pre_rst", int'(cnt_w), 6);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_cnt", int'(cnt_w), 0);
    check("arst_wr", int'(wr_w), 0);
    check_all();
    @(posedge clk);
    #2 rst = 1'b1;
    step(0, 0, 4'd0, 1, 1, 0);
    check("resume", int'(cnt_w), 1);

    for (int i = 0; i < 300; i++) begin
      step(($urandom % 16) == 0, ($urandom % 8) == 0,
           4'($urandom), ($urandom % 4) != 0,
           1'($urandom), 0);
    end

    repeat (25) step(0, 0, 4'd0, 0, 1, 1);
    check("cas_hi", int'(cnt_hi), 2);
    check("cas_lo", int'(cnt_lo), 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
